// File: rtl/prga_param.sv
// RC4 PRGA engine: decrypts a length-prefixed CT buffer into PT using the S permutation,
// with an optional validate mode that aborts on the first non-printable plaintext byte.
module prga_param #(
  parameter int         MSG_AW   = 8,
  parameter bit         CHECK_EN = 1'b1,
  parameter logic [7:0] MIN_CHAR = 8'h20,
  parameter logic [7:0] MAX_CHAR = 8'h7E
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              rdy,
  input  logic              mode,
  output logic              done,
  output logic              valid,
  output logic              err,
  output logic [7:0]        s_addr,
  input  logic [7:0]        s_rddata,
  output logic [7:0]        s_wrdata,
  output logic              s_wren,
  output logic [MSG_AW-1:0] ct_addr,
  input  logic [7:0]        ct_rddata,
  output logic [MSG_AW-1:0] pt_addr,
  output logic [7:0]        pt_wrdata,
  output logic              pt_wren
);

  localparam int         CAP  = (MSG_AW >= 8) ? 255 : ((1 << MSG_AW) - 1);
  localparam logic [7:0] CAP8 = 8'(CAP);
  localparam int         KW   = (MSG_AW > 8) ? MSG_AW : 8;

  typedef enum logic [3:0] {
    IDLE, LEN_REQ, LEN_GET, SI_REQ, SI_GET, SJ_REQ, SJ_GET,
    SW_J, SW_I, PAD_REQ, PAD_GET, DONE
  } state_t;

  state_t          state, state_n;
  logic [7:0]      i, j, len, s_i, s_j;
  logic [KW-1:0]   k;
  logic            mode_q;
  logic [7:0]      pad;
  logic            too_long, bad, last;

  assign pad      = s_rddata ^ ct_rddata;
  assign too_long = ct_rddata > CAP8;
  assign bad      = mode_q && ((pad < MIN_CHAR) || (pad > MAX_CHAR));
  // k only counts up to len (<= 255), so its low byte is the whole story
  assign last     = (k[7:0] == len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    rdy       = 1'b0;
    done      = 1'b0;
    s_addr    = 8'h00;
    s_wrdata  = 8'h00;
    s_wren    = 1'b0;
    ct_addr   = '0;
    pt_addr   = '0;
    pt_wrdata = 8'h00;
    pt_wren   = 1'b0;
    case (state)
      IDLE: begin
        rdy = 1'b1;
        if (en) state_n = LEN_REQ;
      end
      LEN_REQ: state_n = LEN_GET;
      LEN_GET: begin
        if (too_long) state_n = DONE;
        else begin
          pt_wren   = 1'b1;
          pt_wrdata = ct_rddata;
          state_n   = (ct_rddata == 8'h00) ? DONE : SI_REQ;
        end
      end
      SI_REQ: begin s_addr = i; state_n = SI_GET; end
      SI_GET: state_n = SJ_REQ;
      SJ_REQ: begin s_addr = j; state_n = SJ_GET; end
      SJ_GET: state_n = SW_J;
      SW_J: begin
        s_addr = j; s_wrdata = s_i; s_wren = 1'b1; state_n = SW_I;
      end
      // when i==j this second write lands last and restores s_j, leaving S unchanged
      SW_I: begin
        s_addr = i; s_wrdata = s_j; s_wren = 1'b1; state_n = PAD_REQ;
      end
      PAD_REQ: begin
        s_addr  = s_i + s_j;
        ct_addr = k[MSG_AW-1:0];
        state_n = PAD_GET;
      end
      PAD_GET: begin
        pt_addr   = k[MSG_AW-1:0];
        pt_wrdata = pad;
        pt_wren   = 1'b1;
        state_n   = (bad || last) ? DONE : SI_REQ;
      end
      DONE: begin done = 1'b1; state_n = IDLE; end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i <= '0; j <= '0; k <= '0; len <= '0;
      s_i <= '0; s_j <= '0; mode_q <= 1'b0;
      valid <= 1'b0; err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (en) begin
          mode_q <= CHECK_EN ? mode : 1'b0;
          valid  <= 1'b0;
          err    <= 1'b0;
          i      <= '0;
          j      <= '0;
        end
        LEN_GET: begin
          len <= ct_rddata;
          if (too_long) err <= 1'b1;
          else begin
            k     <= KW'(1);
            valid <= 1'b1;
            if (ct_rddata != 8'h00) i <= i + 8'd1;
          end
        end
        SI_GET: begin s_i <= s_rddata; j <= j + s_rddata; end
        SJ_GET: s_j <= s_rddata;
        PAD_GET: begin
          if (bad) valid <= 1'b0;
          else if (!last) begin
            k <= k + KW'(1);
            i <= i + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prga_param.sv
// Bench for prga_param: memory models, RC4 reference scoreboard, directed and random runs.
module tb_prga_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en, mode, rdy, done, valid, err;
  logic [7:0] s_addr, s_rddata, s_wrdata, ct_addr, ct_rddata, pt_addr, pt_wrdata;
  logic       s_wren, pt_wren;

  logic       en4, rdy4, done4, valid4, err4, s4_wren, pt4_wren;
  logic [7:0] s4_addr, s4_wrdata, ct4_rddata, pt4_wrdata;
  logic [7:0] s4_rddata;
  logic [3:0] ct4_addr, pt4_addr;
  assign s4_rddata = 8'h00;

  prga_param #(.MSG_AW(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .mode(mode), .done(done),
    .valid(valid), .err(err), .s_addr(s_addr), .s_rddata(s_rddata),
    .s_wrdata(s_wrdata), .s_wren(s_wren), .ct_addr(ct_addr), .ct_rddata(ct_rddata),
    .pt_addr(pt_addr), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren));

  prga_param #(.MSG_AW(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en4), .rdy(rdy4), .mode(1'b0), .done(done4),
    .valid(valid4), .err(err4), .s_addr(s4_addr), .s_rddata(s4_rddata),
    .s_wrdata(s4_wrdata), .s_wren(s4_wren), .ct_addr(ct4_addr), .ct_rddata(ct4_rddata),
    .pt_addr(pt4_addr), .pt_wrdata(pt4_wrdata), .pt_wren(pt4_wren));

  logic [7:0] smem [256];
  logic [7:0] ctmem [256];
  logic [7:0] ct4mem [16];
  logic [15:0] obs_q[$], exp_q[$];
  int pt4_cnt = 0;

  always @(posedge clk) begin
    s_rddata  <= smem[s_addr];
    ct_rddata <= ctmem[ct_addr];
    ct4_rddata <= ct4mem[ct4_addr];
    if (s_wren) smem[s_addr] <= s_wrdata;
    if (pt_wren) obs_q.push_back({pt_addr, pt_wrdata});
    if (pt4_wren) pt4_cnt <= pt4_cnt + 1;
  end

  int nvec = 0, nerr = 0;
  logic [7:0] exp_s [256];
  int  exp_nb;
  bit  exp_valid;

  // independent RC4 reference over the current S/CT contents
  task automatic model(input bit m);
    logic [7:0] ms [256];
    logic [7:0] mi, mj, t, p, l;
    ms = smem;
    exp_q.delete();
    l = ctmem[0];
    exp_q.push_back({8'h00, l});
    mi = 0; mj = 0; exp_nb = 0; exp_valid = 1;
    for (int kk = 1; kk <= int'(l); kk++) begin
      mi = mi + 8'd1;
      mj = mj + ms[mi];
      t = ms[mi]; ms[mi] = ms[mj]; ms[mj] = t;
      p = ms[8'(ms[mi] + ms[mj])] ^ ctmem[kk];
      exp_q.push_back({8'(kk), p});
      exp_nb++;
      if (m && (p < 8'h20 || p > 8'h7E)) begin exp_valid = 0; break; end
    end
    exp_s = smem;
    exp_s = ms;
  endtask

  task automatic set_identity();
    for (int a = 0; a < 256; a++) smem[a] = 8'(a);
  endtask

  task automatic run(input bit m, output int lat);
    obs_q.delete();
    @(negedge clk); en = 1; mode = m;
    @(posedge clk); #1 en = 0;
    lat = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk); lat++;
      if (done) break;
      if (c == 3999) lat = -1;
    end
  endtask

  task automatic check_run(input string name, input int lat);
    int diffs;
    logic [15:0] e, o;
    nvec++;
    if (lat !== 3 + 8 * exp_nb) begin
      nerr++; $display("FAIL %s latency: got %0d want %0d", name, lat, 3 + 8 * exp_nb);
    end
    nvec++;
    if (valid !== exp_valid || err !== 1'b0) begin
      nerr++; $display("FAIL %s valid/err: got %b/%b want %b/0", name, valid, err, exp_valid);
    end
    nvec++;
    if (obs_q.size() != exp_q.size()) begin
      nerr++; $display("FAIL %s pt write count: got %0d want %0d", name, obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      nvec++;
      if (o !== e) begin
        nerr++; $display("FAIL %s pt[%0h]: got %h want %h", name, e[15:8], o, e);
      end
    end
    diffs = 0;
    for (int a = 0; a < 256; a++) if (smem[a] !== exp_s[a]) diffs++;
    nvec++;
    if (diffs != 0) begin
      nerr++; $display("FAIL %s final S: got %0d differing entries want 0", name, diffs);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; en = 0; mode = 0; en4 = 0;
    repeat (3) @(negedge clk);
    nvec++;
    if (rdy !== 1 || done !== 0 || valid !== 0 || err !== 0) begin
      nerr++; $display("FAIL reset status: got rdy%b done%b valid%b err%b want 1000", rdy, done, valid, err);
    end
    nvec++;
    if (s_wren !== 0 || pt_wren !== 0 || s_addr !== 0 || ct_addr !== 0 || pt_addr !== 0 || s_wrdata !== 0 || pt_wrdata !== 0) begin
      nerr++; $display("FAIL reset mem ports: got s_wren%b pt_wren%b s_addr%h ct_addr%h want all 0", s_wren, pt_wren, s_addr, ct_addr);
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_one_byte();
    int lat;
    set_identity(); ctmem[0] = 8'h01; ctmem[1] = 8'h43;
    model(0);
    run(0, lat);
    nvec++;
    if (smem[1] !== 8'h01 || smem[2] !== 8'h02) begin
      nerr++; $display("FAIL one_byte S12: got %h %h want 01 02", smem[1], smem[2]);
    end
    nvec++;
    if (obs_q.size() == 2 && obs_q[1] !== 16'h0141) begin
      nerr++; $display("FAIL one_byte pt1: got %h want 0141", obs_q[1]);
    end
    check_run("one_byte", lat);
  endtask

  task automatic test_two_byte();
    int lat;
    set_identity(); ctmem[0] = 8'h02; ctmem[1] = 8'h43; ctmem[2] = 8'h47;
    model(0);
    run(0, lat);
    nvec++;
    if (smem[2] !== 8'h03 || smem[3] !== 8'h02) begin
      nerr++; $display("FAIL two_byte S23: got %h %h want 03 02", smem[2], smem[3]);
    end
    nvec++;
    if (lat !== 19) begin nerr++; $display("FAIL two_byte done cycle: got %0d want 19", lat); end
    check_run("two_byte", lat);
  endtask

  task automatic test_validate_abort();
    int lat;
    set_identity(); ctmem[0] = 8'h02; ctmem[1] = 8'h43; ctmem[2] = 8'h02;
    model(1);
    run(1, lat);
    nvec++;
    if (valid !== 0 || obs_q.size() != 3 || obs_q[2] !== 16'h0207) begin
      nerr++; $display("FAIL abort pt2/valid: got valid %b n %0d want valid 0 pt2 0207", valid, obs_q.size());
    end
    check_run("validate_abort", lat);
    // printable message passes validate mode
    set_identity(); ctmem[0] = 8'h02; ctmem[1] = 8'h43; ctmem[2] = 8'h47;
    model(1);
    run(1, lat);
    check_run("validate_ok", lat);
  endtask

  task automatic test_zero_len();
    int lat;
    set_identity(); ctmem[0] = 8'h00;
    model(0);
    run(0, lat);
    check_run("zero_len", lat);
  endtask

  task automatic test_err();
    int lat;
    ct4mem[0] = 8'h10;
    pt4_cnt = 0;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk); en4 = 1;
      @(posedge clk); #1 en4 = 0;
      @(negedge clk); lat = 1;
      nvec++;
      if (err4 !== 0 || valid4 !== 0) begin
        nerr++; $display("FAIL err start clear run%0d: got err %b valid %b want 0 0", r, err4, valid4);
      end
      for (int c = 0; c < 100 && !done4; c++) begin @(negedge clk); lat++; end
      nvec++;
      if (lat !== 3) begin nerr++; $display("FAIL err latency run%0d: got %0d want 3", r, lat); end
      nvec++;
      if (r == 0 && (err4 !== 1 || valid4 !== 0 || pt4_cnt != 0)) begin
        nerr++; $display("FAIL err result: got err %b valid %b writes %0d want 1 0 0", err4, valid4, pt4_cnt);
      end else if (r == 1 && (err4 !== 0 || valid4 !== 1 || pt4_cnt != 1)) begin
        nerr++; $display("FAIL err cleared: got err %b valid %b writes %0d want 0 1 1", err4, valid4, pt4_cnt);
      end
      @(negedge clk);
      nvec++;
      if (r == 0 && err4 !== 1) begin nerr++; $display("FAIL err hold: got %b want 1", err4); end
      else if (r == 1 && rdy4 !== 1) begin nerr++; $display("FAIL err idle: got rdy %b want 1", rdy4); end
      ct4mem[0] = 8'h00;
    end
  endtask

  task automatic test_reset_midrun();
    int c;
    set_identity(); ctmem[0] = 8'h02; ctmem[1] = 8'h43; ctmem[2] = 8'h47;
    @(negedge clk); en = 1; mode = 0;
    @(posedge clk); #1 en = 0;
    for (c = 0; c < 50; c++) begin @(negedge clk); if (s_wren) break; end
    nvec++;
    if (c == 50) begin nerr++; $display("FAIL midrun reach SW_J: got timeout want s_wren"); end
    #2 rst_n = 0;
    #1;
    nvec++;
    if (s_wren !== 0 || pt_wren !== 0 || rdy !== 1 || done !== 0) begin
      nerr++; $display("FAIL midrun async reset: got s_wren%b pt_wren%b rdy%b done%b want 0010", s_wren, pt_wren, rdy, done);
    end
    @(negedge clk); rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_ignore_en();
    int lat;
    set_identity(); ctmem[0] = 8'h02; ctmem[1] = 8'h43; ctmem[2] = 8'h47;
    model(0);
    obs_q.delete();
    @(negedge clk); en = 1; mode = 0;
    @(posedge clk); #1 en = 0;
    lat = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk); lat++;
      en = (lat == 4);
      if (done) break;
    end
    en = 0;
    check_run("ignore_en", lat);
    @(negedge clk);
    @(negedge clk);
    nvec++;
    if (rdy !== 1) begin nerr++; $display("FAIL ignore_en no restart: got rdy %b want 1", rdy); end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    logic [15:0] tmp[$];
    set_identity(); ctmem[0] = 8'h01; ctmem[1] = 8'h43;
    model(0);
    tmp = exp_q; exp_q = {exp_q, tmp};
    obs_q.delete();
    @(negedge clk); en = 1; mode = 0;
    lat1 = 0;
    for (int c = 0; c < 200; c++) begin @(negedge clk); lat1++; if (done) break; end
    @(negedge clk);
    nvec++;
    if (rdy !== 1) begin nerr++; $display("FAIL b2b idle gap: got rdy %b want 1", rdy); end
    @(negedge clk);
    nvec++;
    if (rdy !== 0) begin nerr++; $display("FAIL b2b restart: got rdy %b want 0", rdy); end
    en = 0;
    lat2 = 1;
    for (int c = 0; c < 200 && !done; c++) begin @(negedge clk); lat2++; end
    nvec++;
    if (lat1 !== 11 || lat2 !== 11) begin
      nerr++; $display("FAIL b2b latency: got %0d %0d want 11 11", lat1, lat2);
    end
    exp_nb = 1;
    check_run("back_to_back", lat2);
  endtask

  task automatic test_random();
    int lat, r;
    logic [7:0] t;
    for (int n = 0; n < 3; n++) begin
      set_identity();
      for (int a = 255; a > 0; a--) begin
        r = $urandom_range(a, 0);
        t = smem[a]; smem[a] = smem[r]; smem[r] = t;
      end
      ctmem[0] = 8'(30 + n * 40);
      for (int a = 1; a < 256; a++) ctmem[a] = 8'($urandom);
      model(n == 2);
      run(n == 2, lat);
      check_run("random", lat);
    end
  endtask

  initial begin
    test_reset();
    test_one_byte();
    test_two_byte();
    test_validate_abort();
    test_zero_len();
    test_err();
    test_reset_midrun();
    test_ignore_en();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/prga_param.md
Name: prga_param

Overview:
Parametrised next-generation RC4 pseudo-random generation (PRGA) engine. It runs after key scheduling has left the permutation S in S-memory. It reads a length-prefixed ciphertext from CT-memory, XORs it with the keystream and writes a length-prefixed plaintext to PT-memory. Message depth is configurable, and an optional validate mode aborts on the first non-printable plaintext byte, for use by the key-search (cracker) controller.

Parameters:
MSG_AW, 8, address width of CT/PT memories; max usable length = min(255, 2^MSG_AW - 1)
CHECK_EN, 1, 1 = validate mode supported; 0 = mode input ignored (always decrypt)
MIN_CHAR, 8'h20, lowest byte value accepted as printable
MAX_CHAR, 8'h7E, highest byte value accepted as printable

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
en  in  1  start request, sampled only while rdy=1
rdy  out  1  idle/ready; high exactly when FSM is in IDLE
mode  in  1  0 = full decrypt, 1 = validate (abort on non-printable); sampled with en
done  out  1  one-cycle pulse at end of every run (normal, abort or error)
valid  out  1  run result; held from done until next accepted start
err  out  1  length exceeds capacity; held from done until next accepted start
s_addr  out  8  S-memory address
s_rddata  in  8  S-memory read data; synchronous read, valid the cycle after address
s_wrdata  out  8  S-memory write data
s_wren  out  1  S-memory write enable
ct_addr  out  MSG_AW  CT-memory address
ct_rddata  in  8  CT-memory read data; 1-cycle latency
pt_addr  out  MSG_AW  PT-memory address
pt_wrdata  out  8  PT-memory write data
pt_wren  out  1  PT-memory write enable

Behaviour:
- Reset (async, any state): FSM to IDLE; i=j=k=L=0; done=valid=err=0; all addresses, wrdata and wren =0; rdy=1.
- Outputs are combinational from state plus registers. Addresses are 0 and wren is 0 in every state not listed below.
- Start: rdy=1 and en=1 at a rising edge -> latch mode (forced 0 if CHECK_EN=0), clear valid/err, i=j=0, go to LEN_REQ. en while rdy=0 is ignored.
- LEN_REQ: ct_addr=0.
- LEN_GET: L=ct_rddata.
  - If L > 2^MSG_AW-1: err=1, no writes, go to DONE.
  - Else write pt[0]=L (pt_wren=1), set k=1, valid=1.
  - If L=0, go to DONE; otherwise i=i+1 and go to SI_REQ.
- Per byte, exactly 8 states:
  - SI_REQ: s_addr=i.
  - SI_GET: s_i=s_rddata; j=j+s_i mod 256.
  - SJ_REQ: s_addr=j.
  - SJ_GET: s_j=s_rddata.
  - SW_J: write S[j]=s_i.
  - SW_I: write S[i]=s_j.
  - PAD_REQ: s_addr=(s_i+s_j) mod 256; ct_addr=k.
  - PAD_GET: pt_addr=k, pt_wrdata=s_rddata^ct_rddata, pt_wren=1.
- After PAD_GET:
  - If mode=1 and pt_wrdata is outside [MIN_CHAR,MAX_CHAR] (inclusive): valid=0, go to DONE. The offending byte is still written.
  - Else if k==L, go to DONE.
  - Else k=k+1, i=i+1 mod 256, go to SI_REQ.
- DONE: done=1 for one cycle, then IDLE.
- Latency: rdy low for 3+8L cycles on a full run; 3 cycles on err or L=0.
- i==j: both swap writes hit the same address; second write (s_j) wins, and S is unchanged (correct RC4).
- i, j and pad index wrap mod 256. k never wraps because L is bounded.
- S is mutated by every run. The caller must re-run key scheduling before the next run.
- en held high through DONE starts a new run in the cycle after DONE (from IDLE).
- Reset mid-run aborts immediately. Partial PT/S contents are undefined; no done pulse.

Test Plan:
- S=identity, ct={01,43}, mode=0 -> pt={01,41}; S[1]=1, S[2]=2 unchanged; done exactly 11 cycles after start edge; valid=1, err=0.
- S=identity, ct={02,43,47}, mode=0 -> pt={02,41,42}; S[2]=3, S[3]=2 after run; done at cycle 19.
- S=identity, ct={02,43,02}, mode=1 -> pt[1]=41 accepted, pt[2]=07 written, then abort; valid=0; done at cycle 19.
- MSG_AW=4, ct[0]=8'h10 -> err=1, valid=0, no pt_wren ever asserted, done at cycle 3; next start clears err.
- ct[0]=00 -> only pt[0]=00 written; done at cycle 3, valid=1.
- Assert rst_n low mid-run (during SW_J) -> all wren 0 and rdy=1 asynchronously. Pulse en while rdy=0 -> ignored. en held high -> back-to-back runs with one IDLE cycle between.
